// File: rtl/z16_pkg.sv
// Z16 sequencer shared definitions: state encoding, opcode map, PC step
// and small decode helpers used by the sequencer control path.
package z16_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [OP_W-1:0] OP_ADDI  = 4'h9;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'hA;
  localparam logic [OP_W-1:0] OP_STORE = 4'hB;
  localparam logic [OP_W-1:0] OP_BR_LO = 4'hC;
  localparam logic [OP_W-1:0] OP_BR_HI = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  // What EXEC does with an opcode.
  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_MEM    = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_HALT   = 2'd3
  } op_class_e;

  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    op_class_e cls;
    cls = CLS_HALT;
    if (op <= OP_ADDI) begin
      cls = CLS_ALU;
    end else if (op >= OP_LOAD && op <= OP_STORE) begin
      cls = CLS_MEM;
    end else if (op >= OP_BR_LO && op <= OP_BR_HI) begin
      cls = CLS_BRANCH;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

  // Instructions are halfword aligned; a branch target never lands on an odd byte.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/z16_req_timeout.sv
// Wait counter for an outstanding memory request; flags expiry on the
// last allowed unacknowledged cycle.
module z16_req_timeout
  import z16_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  // Saturates at LAST; the sequencer leaves the request state on expiry anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + TO_W'(1);
    end
  end

  assign expire_c = en && (count == LAST);

endmodule

// File: rtl/z16_seq_ctrl.sv
// Z16 multi-cycle sequencer: walks each instruction through fetch, decode,
// execute, memory and write-back, owning the PC and the shared memory port.
module z16_seq_ctrl
  import z16_pkg::*;
#(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_run,
  input  logic [OP_W-1:0] i_opcode,
  input  logic            i_rd_wen,
  input  logic            i_mem_wen,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  input  logic            i_mem_ack,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic            o_mem_sel_data,
  output logic            o_ir_load,
  output logic            o_rf_wen,
  output logic [PC_W-1:0] o_pc,
  output logic [ST_W-1:0] o_state,
  output logic            o_retire,
  output logic [CNT_W-1:0] o_instr_count,
  output logic            o_halted,
  output logic            o_fault
);

  state_e           state;
  state_e           state_next;
  state_e           boundary_next;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W-1:0]  pc_seq;
  logic [CNT_W-1:0] instr_count;
  logic             fault;
  op_class_e        op_class;

  logic req_c;
  logic mem_we_c;
  logic sel_data_c;
  logic ir_load_c;
  logic rf_wen_c;
  logic retire_c;
  logic fault_set_c;
  logic expire_c;

  // Request is a pure function of state so the wait counter never loops back
  // through the next-state logic.
  assign req_c         = (state == ST_FETCH) || (state == ST_MEM);
  assign boundary_next = i_run ? ST_FETCH : ST_IDLE;
  assign pc_seq        = pc + PC_STEP;
  assign op_class      = classify(i_opcode);

  z16_req_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (!req_c || i_mem_ack),
    .en      (req_c && !i_mem_ack),
    .expire_c(expire_c)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    mem_we_c    = 1'b0;
    sel_data_c  = 1'b0;
    ir_load_c   = 1'b0;
    rf_wen_c    = 1'b0;
    retire_c    = 1'b0;
    fault_set_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_run) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (i_mem_ack) begin
          ir_load_c  = 1'b1;
          state_next = ST_DECODE;
        end else if (expire_c) begin
          fault_set_c = 1'b1;
          state_next  = ST_HALT;
        end
      end

      ST_DECODE: begin
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        case (op_class)
          CLS_ALU:    state_next = ST_WB;
          CLS_MEM:    state_next = ST_MEM;
          CLS_BRANCH: begin
            retire_c   = 1'b1;
            pc_next    = i_branch_taken ? align_pc(i_branch_target) : pc_seq;
            state_next = boundary_next;
          end
          default:    state_next = ST_HALT;
        endcase
      end

      // Load/store data phase; stores retire here, loads continue to write-back.
      ST_MEM: begin
        sel_data_c = 1'b1;
        mem_we_c   = i_mem_wen;
        if (i_mem_ack) begin
          if (i_opcode == OP_STORE) begin
            retire_c   = 1'b1;
            pc_next    = pc_seq;
            state_next = boundary_next;
          end else begin
            state_next = ST_WB;
          end
        end else if (expire_c) begin
          fault_set_c = 1'b1;
          state_next  = ST_HALT;
        end
      end

      ST_WB: begin
        rf_wen_c   = i_rd_wen;
        retire_c   = 1'b1;
        pc_next    = pc_seq;
        state_next = boundary_next;
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc          <= PC_RESET;
      instr_count <= '0;
      fault       <= 1'b0;
    end else begin
      pc <= pc_next;
      if (retire_c) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (fault_set_c) begin
        fault <= 1'b1;
      end
    end
  end

  assign o_mem_req      = req_c;
  assign o_mem_we       = mem_we_c;
  assign o_mem_sel_data = sel_data_c;
  assign o_ir_load      = ir_load_c;
  assign o_rf_wen       = rf_wen_c;
  assign o_retire       = retire_c;
  assign o_pc           = pc;
  assign o_state        = state;
  assign o_instr_count  = instr_count;
  assign o_halted       = (state == ST_HALT);
  assign o_fault        = fault;

endmodule
